wb_bus_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter for the test engine bus.
- Master 0 is the test-program processor. Master 1 is the host/loader path, which writes program memory and reads result registers.
- The slave side drives the shared register/program-memory interconnect.
- Grant is held for a whole Wishbone cycle, from CYC rise to CYC fall. Masters get round-robin fairness.

---
 rtl/wb_bus_arbiter_pkg.sv | 18 +
 rtl/wb_bus_arbiter_if.sv | 18 +
 rtl/wb_arb_rr_pick.sv | 27 ++
 rtl/wb_bus_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_bus_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_bus_arbiter_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: FSM states, grant
// one-hot values and the default ack-watchdog limit.
package wb_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    REST   = 2'd3
  } arbState_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Wishbone classic bus bundle. "master" is the view of whoever starts cycles,
// "slave" is the view of whoever answers them.
interface wb_bus_arbiter_if #(
  parameter int ADDRESS_WIDTH = 24,
  parameter int DATA_WIDTH    = 16
);
  logic [ADDRESS_WIDTH-1:0] adr;
  logic [DATA_WIDTH-1:0]    datW;
  logic [DATA_WIDTH-1:0]    datR;
  logic                     cyc;
  logic                     stb;
  logic                     we;
  logic                     ack;
  logic                     err;

  modport master (output adr, datW, cyc, stb, we, input datR, ack, err);
  modport slave  (input adr, datW, cyc, stb, we, output datR, ack, err);
endinterface

// File: rtl/wb_arb_rr_pick.sv
// Combinational round-robin pick: the first requester after lastGrant
// (wrapping) wins. Written for N requesters, used here with two.
module wb_arb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] lastGrant,
  output logic [N-1:0]  pick
);

  always_comb begin
    int   idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(lastGrant) + off) % N;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone arbiter, grant held for a whole CYC.
// Define WB_BUS_ARBITER_TIMEOUT_EN to add the ack watchdog and ErrO pulses.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  wb_bus_arbiter_if.slave  m0,
  wb_bus_arbiter_if.slave  m1,
  wb_bus_arbiter_if.master s,
  output logic [1:0]       grant
);

  // The watchdog counter is 16 bits wide; reject limits it cannot reach.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be in 2..65536");
  end

  arbState_t  state, stateNext;
  logic       lastGrant;
  logic [1:0] cycIn, req, pick;
  logic       toHit;

  assign cycIn = {m1.cyc, m0.cyc};

`ifdef WB_BUS_ARBITER_TIMEOUT_EN
  logic [15:0] wdCnt;
  logic [1:0]  blocked;
  logic        stall;

  assign stall = !s.ack &&
                 (((state == GRANT0) && m0.cyc && m0.stb) ||
                  ((state == GRANT1) && m1.cyc && m1.stb));
  assign toHit = stall && (wdCnt == 16'(TIMEOUT_CYCLES - 1));
  // A master that timed out must drop CYC once before it can win again.
  assign req   = cycIn & ~blocked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdCnt   <= '0;
      blocked <= '0;
    end else begin
      if (!stall || (stateNext != state)) wdCnt <= '0;
      else                                wdCnt <= wdCnt + 16'd1;
      blocked <= (blocked & cycIn) |
                 ({state == GRANT1, state == GRANT0} & {2{toHit}});
    end
  end
`else
  assign toHit = 1'b0;
  assign req   = cycIn;
`endif

  wb_arb_rr_pick #(.N(2), .IW(1)) uPick (
    .req      (req),
    .lastGrant(lastGrant),
    .pick     (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lastGrant <= 1'b1;
    end else begin
      state <= stateNext;
      if (state == IDLE && stateNext == GRANT0) lastGrant <= 1'b0;
      if (state == IDLE && stateNext == GRANT1) lastGrant <= 1'b1;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (pick[0])               stateNext = GRANT0;
               else if (pick[1])          stateNext = GRANT1;
      GRANT0:  if (!m0.cyc || toHit)      stateNext = REST;
      GRANT1:  if (!m1.cyc || toHit)      stateNext = REST;
      REST:                               stateNext = IDLE;
      default:                            stateNext = IDLE;
    endcase
  end

  // Routing depends only on state, so an ack in the release cycle still lands.
  always_comb begin
    s.adr   = '0;
    s.datW  = '0;
    s.cyc   = 1'b0;
    s.stb   = 1'b0;
    s.we    = 1'b0;
    m0.datR = '0;
    m0.ack  = 1'b0;
    m0.err  = 1'b0;
    m1.datR = '0;
    m1.ack  = 1'b0;
    m1.err  = 1'b0;
    grant   = GRANT_NONE;
    case (state)
      GRANT0: begin
        s.adr   = m0.adr;
        s.datW  = m0.datW;
        s.cyc   = m0.cyc & ~toHit;
        s.stb   = m0.stb & m0.cyc & ~toHit;
        s.we    = m0.we;
        m0.datR = s.datR;
        m0.ack  = s.ack;
        m0.err  = toHit;
        grant   = GRANT_M0;
      end
      GRANT1: begin
        s.adr   = m1.adr;
        s.datW  = m1.datW;
        s.cyc   = m1.cyc & ~toHit;
        s.stb   = m1.stb & m1.cyc & ~toHit;
        s.we    = m1.we;
        m1.datR = s.datR;
        m1.ack  = s.ack;
        m1.err  = toHit;
        grant   = GRANT_M1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter; the watchdog scenario runs when
// WB_BUS_ARBITER_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=8).
module tb_wb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  int         chkCnt = 0;
  int         errCnt = 0;

  wb_bus_arbiter_if #(.ADDRESS_WIDTH(24), .DATA_WIDTH(16)) m0If ();
  wb_bus_arbiter_if #(.ADDRESS_WIDTH(24), .DATA_WIDTH(16)) m1If ();
  wb_bus_arbiter_if #(.ADDRESS_WIDTH(24), .DATA_WIDTH(16)) sIf ();

  wb_bus_arbiter #(.ADDRESS_WIDTH(24), .DATA_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .m0   (m0If),
    .m1   (m1If),
    .s    (sIf),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] expG;
    rst = 1'b1;
    m0If.adr = '0; m0If.datW = '0; m0If.cyc = 0; m0If.stb = 0; m0If.we = 0;
    m1If.adr = '0; m1If.datW = '0; m1If.cyc = 0; m1If.stb = 0; m1If.we = 0;
    sIf.datR = '0; sIf.ack = 0; sIf.err = 0;
    #3;
    chk("rst_grant", grant, 2'b00);
    chk("rst_scyc", sIf.cyc, 1'b0);
    chk("rst_sstb", sIf.stb, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // m0 read of 0x10005, slave answers 0xBEEF two clocks in
    m0If.adr = 24'h010005; m0If.cyc = 1; m0If.stb = 1;
    #1 chk("t1_latency", grant, 2'b00);
    tick();
    chk("t1_grant", grant, 2'b01);
    chk("t1_sadr", sIf.adr, 24'h010005);
    chk("t1_sstb", sIf.stb, 1'b1);
    tick();
    tick();
    sIf.ack = 1; sIf.datR = 16'hBEEF;
    #1;
    chk("t1_m0dat", m0If.datR, 16'hBEEF);
    chk("t1_m0ack", m0If.ack, 1'b1);
    chk("t1_m1ack", m1If.ack, 1'b0);
    chk("t1_m1dat", m1If.datR, 16'h0000);
    tick();
    sIf.ack = 0; m0If.cyc = 0; m0If.stb = 0;
    tick();
    chk("t1_rest_cyc", sIf.cyc, 1'b0);
    chk("t1_rest_grant", grant, 2'b00);
    tick();

    // simultaneous CYC right after reset: m0 first, then m1
    doReset();
    m0If.cyc = 1; m1If.cyc = 1; m1If.adr = 24'h0ABCDE; m1If.stb = 1;
    tick();
    chk("t2_first", grant, 2'b01);
    m0If.cyc = 0;
    m0If.stb = 1;  // STB without CYC must not request
    tick();
    chk("t2_rest", grant, 2'b00);
    chk("t2_rest_cyc", sIf.cyc, 1'b0);
    tick();
    chk("t2_idle", grant, 2'b00);
    tick();
    chk("t2_second", grant, 2'b10);
    chk("t2_sadr", sIf.adr, 24'h0ABCDE);
    m0If.stb = 0; m1If.cyc = 0; m1If.stb = 0;
    tick();
    tick();

    // m1 write queued behind a long m0 hold
    m0If.adr = 24'h000020; m0If.cyc = 1; m0If.stb = 1; m0If.we = 0;
    tick();
    chk("t4_m0grant", grant, 2'b01);
    m1If.adr = 24'h010000; m1If.datW = 16'h1234; m1If.cyc = 1; m1If.stb = 1; m1If.we = 1;
    tick();
    chk("t4_hold", grant, 2'b01);
    chk("t4_swe_m0", sIf.we, 1'b0);
    chk("t4_sadr_m0", sIf.adr, 24'h000020);
    sIf.ack = 1;
    #1;
    chk("t4_m0ack", m0If.ack, 1'b1);
    chk("t4_m1ack_blk", m1If.ack, 1'b0);
    sIf.ack = 0;
    repeat (3) tick();
    chk("t4_longhold", grant, 2'b01);
    m0If.cyc = 0; m0If.stb = 0;
    tick();
    chk("t4_rest", grant, 2'b00);
    tick();
    chk("t4_idle", grant, 2'b00);
    tick();
    chk("t4_m1grant", grant, 2'b10);
    chk("t4_swe_m1", sIf.we, 1'b1);
    chk("t4_sdat", sIf.datW, 16'h1234);
    chk("t4_sadr_m1", sIf.adr, 24'h010000);
    sIf.ack = 1;
    #1;
    chk("t4_m1ack", m1If.ack, 1'b1);
    chk("t4_m0ack_blk", m0If.ack, 1'b0);
    sIf.ack = 0; m1If.cyc = 0; m1If.stb = 0; m1If.we = 0;
    tick();
    tick();

    // async reset while m1 owns the bus mid-transfer
    m1If.cyc = 1; m1If.stb = 1;
    tick();
    chk("t5_grant", grant, 2'b10);
    chk("t5_sstb", sIf.stb, 1'b1);
    sIf.ack = 1;
    #1;
    chk("t5_m1ack_pre", m1If.ack, 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_scyc", sIf.cyc, 1'b0);
    chk("t5_sstb_rst", sIf.stb, 1'b0);
    chk("t5_grant_rst", grant, 2'b00);
    chk("t5_m1ack_rst", m1If.ack, 1'b0);
    sIf.ack = 0; m0If.cyc = 1;
    rst = 1'b0;
    tick();
    chk("t5_tie", grant, 2'b01);
    m0If.cyc = 0; m1If.cyc = 0; m1If.stb = 0;
    tick();
    tick();

    // both keep re-requesting: strict alternation
    doReset();
    m0If.cyc = 1; m1If.cyc = 1;
    expG = 2'b01;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8 && grant == 2'b00; k++) tick();
      chk($sformatf("t3_alt%0d", i), grant, expG);
      if (grant[0]) m0If.cyc = 0;
      else          m1If.cyc = 0;
      tick();
      m0If.cyc = 1; m1If.cyc = 1;
      expG = {expG[0], expG[1]};
    end
    m0If.cyc = 0; m1If.cyc = 0;
    tick();
    tick();
    doReset();

`ifdef WB_BUS_ARBITER_TIMEOUT_EN
    // slave never acks m0; watchdog fires on the 8th stalled cycle
    m0If.adr = 24'h000030; m0If.cyc = 1; m0If.stb = 1;
    tick();
    chk("t6_grant", grant, 2'b01);
    chk("t6_err_c1", m0If.err, 1'b0);
    repeat (6) tick();
    chk("t6_err_c7", m0If.err, 1'b0);
    m1If.cyc = 1; m1If.stb = 1;
    tick();
    chk("t6_err_c8", m0If.err, 1'b1);
    chk("t6_scyc_forced", sIf.cyc, 1'b0);
    chk("t6_sstb_forced", sIf.stb, 1'b0);
    chk("t6_m1err", m1If.err, 1'b0);
    tick();
    chk("t6_err_pulse", m0If.err, 1'b0);
    chk("t6_rest", grant, 2'b00);
    tick();
    tick();
    chk("t6_m1grant", grant, 2'b10);
    m1If.cyc = 0; m1If.stb = 0;
    tick();
    tick();
    tick();
    chk("t6_m0blocked", grant, 2'b00);
    m0If.cyc = 0;
    tick();
    m0If.cyc = 1;
    tick();
    chk("t6_m0regrant", grant, 2'b01);
`else
    // without the watchdog a missing ack just stalls the bus
    m0If.adr = 24'h000030; m0If.cyc = 1; m0If.stb = 1;
    tick();
    repeat (10) tick();
    chk("t6_nowd_grant", grant, 2'b01);
    chk("t6_nowd_err", m0If.err, 1'b0);
    chk("t6_nowd_scyc", sIf.cyc, 1'b1);
`endif
    m0If.cyc = 0; m0If.stb = 0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", chkCnt, errCnt);
    $finish;
  end

endmodule
